multi_cycle_control: RTL and testbench

- Moore-style multicycle control FSM for the MIPS-subset CPU.
- Consumes op/funct from the DataPath instruction register and drives every DataPath control input.
- It is the controlling end of the DataPath control interface; DataPath and multi_cycle_control are instantiated side by side in the CPU top level.

---
 rtl/multi_cycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Moore multicycle control FSM for the MIPS-subset CPU; drives every DataPath control input.
// Define INTERRUPT_EN to enable the irq-pending latch and the one-cycle INT state at instruction boundaries.
module multi_cycle_control #(
    parameter int unsigned RESET_STATE_HOLD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       irq,
    output logic [1:0] aluControl,
    output logic [1:0] aluSrcB,
    output logic       ALUSrcA,
    output logic       PCSource,
    output logic       PCWrite,
    output logic       isBranch,
    output logic       lorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       isInterrupted,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_RTYPEEX = 4'd7,
        ST_RTYPEWB = 4'd8,
        ST_BEQEX   = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_INT     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_STATE_HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       funct_ok;
    logic       op_illegal;
    state_e     boundary_state;

`ifdef INTERRUPT_EN
    logic pending_q, pending_d;
`else
    logic unused_irq;
    assign unused_irq = irq;
`endif

    always_comb begin
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                   (funct == FN_AND) || (funct == FN_OR);
        op_illegal = !((op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
                       (op == OP_ADDI) || ((op == OP_RTYPE) && funct_ok));
    end

    // Every transition that would land on FETCH is diverted through INT while an interrupt is pending.
`ifdef INTERRUPT_EN
    assign boundary_state = pending_q ? ST_INT : ST_FETCH;
`else
    assign boundary_state = ST_FETCH;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
`ifdef INTERRUPT_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
`ifdef INTERRUPT_EN
            pending_q <= pending_d;
`endif
        end
    end

`ifdef INTERRUPT_EN
    // A held irq re-arms pending even in the cycle INT is clearing it.
    assign pending_d = irq | (pending_q & (state_q != ST_INT));
`endif

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                hold_d = hold_q + 4'd1;
                if (hold_q == HOLD_LAST) state_d = boundary_state;
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (op_illegal)             state_d = boundary_state;
                else if (op == OP_LW || op == OP_SW) state_d = ST_MEMADR;
                else if (op == OP_RTYPE)    state_d = ST_RTYPEEX;
                else if (op == OP_BEQ)      state_d = ST_BEQEX;
                else                        state_d = ST_ADDIEX;
            end
            ST_MEMADR:  state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   state_d = ST_MEMWB;
            ST_MEMWB:   state_d = boundary_state;
            ST_MEMWR:   state_d = boundary_state;
            ST_RTYPEEX: state_d = ST_RTYPEWB;
            ST_RTYPEWB: state_d = boundary_state;
            ST_BEQEX:   state_d = boundary_state;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            ST_ADDIWB:  state_d = boundary_state;
`ifdef INTERRUPT_EN
            ST_INT:     state_d = ST_FETCH;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        aluControl    = ALU_ADD;
        aluSrcB       = SRCB_REGB;
        ALUSrcA       = 1'b0;
        PCSource      = 1'b0;
        PCWrite       = 1'b0;
        isBranch      = 1'b0;
        lorD          = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        isInterrupted = 1'b0;
        illegalOp     = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                IRWrite = 1'b1;
                aluSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            ST_DECODE: begin
                aluSrcB   = SRCB_IMMSH;
                illegalOp = op_illegal;
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            ST_MEMRD:  lorD = 1'b1;
            ST_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEMWR: begin
                lorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_RTYPEEX: begin
                ALUSrcA = 1'b1;
                unique case (funct)
                    FN_SUB:  aluControl = ALU_SUB;
                    FN_AND:  aluControl = ALU_AND;
                    FN_OR:   aluControl = ALU_OR;
                    default: aluControl = ALU_ADD;
                endcase
            end
            ST_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_BEQEX: begin
                ALUSrcA    = 1'b1;
                aluControl = ALU_SUB;
                PCSource   = 1'b1;
                isBranch   = 1'b1;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            ST_ADDIWB: RegWrite = 1'b1;
`ifdef INTERRUPT_EN
            ST_INT: begin
                isInterrupted = 1'b1;
                PCWrite       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed scenarios plus random instruction streams
// compared against an instruction-level reference model (state walk per instruction class).
module tb_multi_cycle_control;

    typedef struct packed {
        logic [1:0] aluControl;
        logic [1:0] aluSrcB;
        logic       ALUSrcA;
        logic       PCSource;
        logic       PCWrite;
        logic       isBranch;
        logic       lorD;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       RegWrite;
        logic       isInterrupted;
        logic       illegalOp;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       irq;
    ctrl_t      act;
    logic [3:0] state;

    int n_asserts = 0;
    int n_fail    = 0;
    bit pending   = 0;
    int exp_seq[$];

    always #5 clk = ~clk;

    multi_cycle_control #(.RESET_STATE_HOLD(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct        (funct),
        .irq          (irq),
        .aluControl   (act.aluControl),
        .aluSrcB      (act.aluSrcB),
        .ALUSrcA      (act.ALUSrcA),
        .PCSource     (act.PCSource),
        .PCWrite      (act.PCWrite),
        .isBranch     (act.isBranch),
        .lorD         (act.lorD),
        .MemWrite     (act.MemWrite),
        .IRWrite      (act.IRWrite),
        .RegDst       (act.RegDst),
        .MemtoReg     (act.MemtoReg),
        .RegWrite     (act.RegWrite),
        .isInterrupted(act.isInterrupted),
        .illegalOp    (act.illegalOp),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b100011 || o == 6'b101011 || o == 6'b000100 || o == 6'b001000) return 1;
        if (o == 6'b000000 && (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25)) return 1;
        return 0;
    endfunction

    // Expected control word for a given visible state of the instruction in flight.
    function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] o, input logic [5:0] f);
        ctrl_t c = '0;
        case (st)
            1:  begin c.IRWrite = 1; c.aluSrcB = 2'b01; c.PCWrite = 1; end
            2:  begin c.aluSrcB = 2'b11; c.illegalOp = !is_legal(o, f); end
            3:  begin c.ALUSrcA = 1; c.aluSrcB = 2'b10; end
            4:  c.lorD = 1;
            5:  begin c.MemtoReg = 1; c.RegWrite = 1; end
            6:  begin c.lorD = 1; c.MemWrite = 1; end
            7:  begin
                    c.ALUSrcA = 1;
                    c.aluControl = (f == 6'h22) ? 2'b01 : (f == 6'h24) ? 2'b10 :
                                   (f == 6'h25) ? 2'b11 : 2'b00;
                end
            8:  begin c.RegDst = 1; c.RegWrite = 1; end
            9:  begin c.ALUSrcA = 1; c.aluControl = 2'b01; c.PCSource = 1; c.isBranch = 1; end
            10: begin c.ALUSrcA = 1; c.aluSrcB = 2'b10; end
            11: c.RegWrite = 1;
            12: begin c.isInterrupted = 1; c.PCWrite = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // State walk for one instruction, FETCH inclusive.
    task automatic build_seq(input logic [5:0] o, input logic [5:0] f);
        if (!is_legal(o, f))   exp_seq = '{1, 2};
        else if (o == 6'b100011) exp_seq = '{1, 2, 3, 4, 5};
        else if (o == 6'b101011) exp_seq = '{1, 2, 3, 6};
        else if (o == 6'b000000) exp_seq = '{1, 2, 7, 8};
        else if (o == 6'b000100) exp_seq = '{1, 2, 9};
        else                     exp_seq = '{1, 2, 10, 11};
    endtask

    // Called just after the edge that enters FETCH; irq_idx selects a step during which irq is high.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f, input int irq_idx);
        op = o;
        funct = f;
        build_seq(o, f);
        for (int i = 0; i < exp_seq.size(); i++) begin
            irq = (i == irq_idx);
            @(negedge clk);
            chk($sformatf("%s step%0d state", name, i), 16'(state), 16'(exp_seq[i]));
            chk($sformatf("%s step%0d ctrl", name, i), act, exp_ctrl(exp_seq[i], o, f));
            @(posedge clk);
            #1;
            if (irq) pending = 1;
            irq = 0;
        end
`ifdef INTERRUPT_EN
        if (pending) begin
            @(negedge clk);
            chk({name, " int state"}, 16'(state), 16'd12);
            chk({name, " int ctrl"}, act, exp_ctrl(12, o, f));
            @(posedge clk);
            #1;
        end
`endif
        pending = 0;
    endtask

    initial begin
        logic [5:0] rop, rfn;
        logic [5:0] rfuncts [4];
        rfuncts = '{6'h20, 6'h22, 6'h24, 6'h25};

        reset = 1'b1;
        op    = '0;
        funct = '0;
        irq   = 1'b0;

        #2;
        chk("reset state", 16'(state), 16'd0);
        chk("reset ctrl", act, 16'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("idle state", 16'(state), 16'd0);
        chk("idle ctrl", act, 16'd0);
        @(posedge clk);
        #1;

        run_instr("lw", 6'b100011, 6'h00, -1);
        run_instr("rsub", 6'b000000, 6'h22, -1);
        run_instr("beq", 6'b000100, 6'h15, -1);
        run_instr("ill_op", 6'b111111, 6'h00, -1);
        run_instr("ill_fn", 6'b000000, 6'h2A, -1);
        run_instr("addi_irq", 6'b001000, 6'h00, 2);
        run_instr("sw", 6'b101011, 6'h00, -1);

        // Reset in the middle of a store: the write strobe must vanish with reset.
        op = 6'b101011;
        funct = 6'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre-reset state", 16'(state), 16'd6);
        chk("pre-reset MemWrite", 16'(act.MemWrite), 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset state", 16'(state), 16'd0);
        chk("async reset ctrl", act, 16'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("hold idle state", 16'(state), 16'd0);
        chk("hold idle ctrl", act, 16'd0);
        @(posedge clk);
        #1;
        chk("post-hold state", 16'(state), 16'd1);
        chk("post-hold IRWrite/PCWrite", {14'd0, act.IRWrite, act.PCWrite}, 16'd3);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: begin rop = 6'b100011; rfn = 6'($urandom); end
                1: begin rop = 6'b101011; rfn = 6'($urandom); end
                2: begin rop = 6'b000000; rfn = rfuncts[$urandom_range(0, 3)]; end
                3: begin rop = 6'b000100; rfn = 6'($urandom); end
                4: begin rop = 6'b001000; rfn = 6'($urandom); end
                default: begin
                    rop = 6'($urandom);
                    rfn = 6'($urandom);
                end
            endcase
            run_instr($sformatf("rnd%0d", n), rop, rfn, -1);
        end

        @(negedge clk);
        chk("final state", 16'(state), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
